// File: rtl/cg_delay_ctrl.sv
// Circular-buffer controller for a clock-gated tap delay line with tap scan.
// Define CG_DELAY_CTRL_OLDEST_FIRST_EN to scan oldest-to-newest.
module cg_delay_ctrl #(
    parameter  int LENGTH = 16,
    parameter  int WIDTH  = 8,
    localparam int PW     = $clog2(LENGTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [LENGTH-1:0]         cg_en,
    output logic [LENGTH*WIDTH-1:0]   reg_in,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [PW-1:0]             rd_idx,
    output logic [PW-1:0]             rd_age,
    output logic                      rd_zero,
    output logic                      rd_last,
    output logic [PW:0]               fill
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SCAN,
        FLUSH
    } state_t;

    localparam logic [PW:0]   LEN  = (PW+1)'(LENGTH);
    localparam logic [PW-1:0] LAST = PW'(LENGTH-1);

    state_t          state, state_nx;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   k;
    logic [PW:0]     pos;
    logic [PW-1:0]   age;
    logic            scan;

    assign in_ready = (state == IDLE) && !flush && !reset;
    assign scan     = (state == SCAN);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (flush)
                    state_nx = FLUSH;
                else if (in_valid)
                    state_nx = WRITE;
            end
            WRITE:   state_nx = SCAN;
            SCAN: begin
                if (rd_ready && rd_last)
                    state_nx = IDLE;
            end
            FLUSH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // pos stays below 2*LENGTH, so one conditional subtract gives the modulo
    always_comb begin
`ifdef CG_DELAY_CTRL_OLDEST_FIRST_EN
        age = LAST - k;
        pos = {1'b0, wr_ptr} + {1'b0, k};
`else
        age = k;
        pos = {1'b0, wr_ptr} + {1'b0, LAST} - {1'b0, k};
`endif
        rd_valid = scan;
        rd_age   = scan ? age : '0;
        rd_idx   = '0;
        if (scan)
            rd_idx = PW'((pos >= LEN) ? pos - LEN : pos);
        rd_zero  = scan && ({1'b0, age} >= fill);
        rd_last  = scan && (k == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            fill   <= '0;
            k      <= '0;
            cg_en  <= '0;
            reg_in <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (flush) begin
                        cg_en  <= '1;
                        reg_in <= '0;
                    end else if (in_valid) begin
                        cg_en  <= {{(LENGTH-1){1'b0}}, 1'b1} << wr_ptr;
                        reg_in <= {LENGTH{in_data}};
                    end
                end
                WRITE: begin
                    cg_en  <= '0;
                    wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                    fill   <= (fill == LEN) ? fill : fill + 1'b1;
                    k      <= '0;
                end
                SCAN: begin
                    if (rd_ready && !rd_last)
                        k <= k + 1'b1;
                end
                FLUSH: begin
                    cg_en  <= '0;
                    wr_ptr <= '0;
                    fill   <= '0;
                end
                default: cg_en <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cg_delay_ctrl.sv
// Scoreboard bench for cg_delay_ctrl (LENGTH=4, WIDTH=8).
module tb_cg_delay_ctrl;

    localparam int L  = 4;
    localparam int W  = 8;
    localparam int PW = 2;

    logic             clk = 0;
    logic             reset = 1;
    logic             in_valid = 0;
    logic [W-1:0]     in_data = 0;
    logic             in_ready;
    logic             flush = 0;
    logic [L-1:0]     cg_en;
    logic [L*W-1:0]   reg_in;
    logic             rd_valid;
    logic             rd_ready = 1;
    logic [PW-1:0]    rd_idx;
    logic [PW-1:0]    rd_age;
    logic             rd_zero;
    logic             rd_last;
    logic [PW:0]      fill;

    cg_delay_ctrl #(.LENGTH(L), .WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush), .cg_en(cg_en), .reg_in(reg_in),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_idx(rd_idx), .rd_age(rd_age),
        .rd_zero(rd_zero), .rd_last(rd_last), .fill(fill)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] idx;
        logic [PW-1:0] age;
        logic          zero;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [L-1:0]   en;
        logic [L*W-1:0] data;
    } cg_t;

    beat_t sbq[$];
    cg_t   cgq[$];
    int    checks = 0;
    int    errors = 0;
    int    m_ptr = 0;
    int    m_fill = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // expected gated write plus the full scan that follows it
    task automatic push_write(input logic [W-1:0] d);
        cg_t   c;
        beat_t b;
        c.en   = L'(1) << m_ptr;
        c.data = {L{d}};
        cgq.push_back(c);
        m_ptr  = (m_ptr + 1) % L;
        m_fill = (m_fill < L) ? m_fill + 1 : L;
        for (int i = 0; i < L; i++) begin
`ifdef CG_DELAY_CTRL_OLDEST_FIRST_EN
            b.idx  = PW'((m_ptr + i) % L);
            b.age  = PW'(L - 1 - i);
            b.zero = (L - 1 - i) >= m_fill;
`else
            b.idx  = PW'((m_ptr - 1 - i + 2 * L) % L);
            b.age  = PW'(i);
            b.zero = i >= m_fill;
`endif
            b.last = (i == L - 1);
            sbq.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_valid && rd_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat idx %0d", rd_idx);
                end else begin
                    beat_t e;
                    e = sbq.pop_front();
                    chk("rd_idx", 64'(rd_idx), 64'(e.idx));
                    chk("rd_age", 64'(rd_age), 64'(e.age));
                    chk("rd_zero", 64'(rd_zero), 64'(e.zero));
                    chk("rd_last", 64'(rd_last), 64'(e.last));
                end
            end
            if (cg_en != 0) begin
                if (cgq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cg_en got %0h", cg_en);
                end else begin
                    cg_t c;
                    c = cgq.pop_front();
                    chk("cg_en", 64'(cg_en), 64'(c.en));
                    chk("reg_in", 64'(reg_in), 64'(c.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL timeout in_ready got 0 want 1");
        end
    endtask

    task automatic send(input logic [W-1:0] d);
        wait_idle();
        in_valid = 1;
        in_data  = d;
        push_write(d);
        step();
        in_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
        sbq.delete();
        cgq.delete();
        m_ptr  = 0;
        m_fill = 0;
    endtask

    initial begin
        step();
        step();
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_cg_en", 64'(cg_en), 0);
        chk("rst_reg_in", 64'(reg_in), 0);
        chk("rst_rd_valid", 64'(rd_valid), 0);
        chk("rst_fill", 64'(fill), 0);
        reset = 0;
        #1;
        chk("idle_in_ready", 64'(in_ready), 1);

        // single sample
        send(8'h11);
        wait_idle();
        chk("fill_one", 64'(fill), 1);

        // five back-to-back samples wrap the pointer
        do_reset();
        for (int i = 1; i <= 5; i++)
            send(8'(i));
        wait_idle();
        chk("fill_sat", 64'(fill), 4);

        // consumer stall on the second beat
        send(8'h66);
        step();
        step();
        rd_ready = 0;
        in_valid = 1;
        in_data  = 8'h77;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 64'(rd_valid), 1);
            chk("stall_age", 64'(rd_age), 1);
            chk("stall_idx", 64'(rd_idx), 64'((m_ptr - 2 + L) % L));
            chk("stall_in_ready", 64'(in_ready), 0);
            chk("stall_cg_en", 64'(cg_en), 0);
            step();
        end
        in_valid = 0;
        rd_ready = 1;
        wait_idle();
        chk("fill_after_stall", 64'(fill), 4);

        // flush beats a simultaneous sample
        do_reset();
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        wait_idle();
        flush    = 1;
        in_valid = 1;
        in_data  = 8'hAA;
        #1;
        chk("flush_in_ready", 64'(in_ready), 0);
        cgq.push_back('{en: '1, data: '0});
        step();
        flush    = 0;
        in_valid = 0;
        m_ptr    = 0;
        m_fill   = 0;
        chk("flush_cg_en", 64'(cg_en), 64'hF);
        chk("flush_reg_in", 64'(reg_in), 0);
        step();
        chk("post_flush_cg_en", 64'(cg_en), 0);
        chk("post_flush_fill", 64'(fill), 0);
        send(8'h5A);
        wait_idle();
        chk("fill_after_flush", 64'(fill), 1);

        // reset during the second scan beat
        send(8'h33);
        step();
        step();
        reset = 1;
        step();
        reset = 0;
        sbq.delete();
        cgq.delete();
        m_ptr  = 0;
        m_fill = 0;
        chk("midrst_rd_valid", 64'(rd_valid), 0);
        chk("midrst_cg_en", 64'(cg_en), 0);
        chk("midrst_fill", 64'(fill), 0);
        send(8'h44);
        wait_idle();
        chk("fill_after_rst", 64'(fill), 1);

        // two samples from empty
        do_reset();
        send(8'hC1);
        send(8'hC2);
        wait_idle();
        chk("fill_two", 64'(fill), 2);

        step();
        step();
        chk("sb_drained", 64'(sbq.size()), 0);
        chk("cg_drained", 64'(cgq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cg_delay_ctrl.md
Name: cg_delay_ctrl

Overview:
- Controller for the clock-gated tap delay line used in the spline-filter input path.
- Replaces shift-every-sample operation with circular-buffer writes: each new sample enables exactly one register slot, so the delay line sees one gated clock per sample.
- Tracks the write pointer and fill level.
- After each write, sequences a handshaked tap scan that gives the filter MAC the physical slot index of each tap in age order.

Parameters:
- LENGTH, 16, number of delay slots (>= 2).
- WIDTH, 8, sample width in bits.
- PW, $clog2(LENGTH), pointer and index width (derived, not overridden).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  new input sample offered.
- in_data  input  WIDTH  input sample.
- in_ready  output  1  sample accepted when in_valid && in_ready.
- flush  input  1  clear all slots; acted on only in IDLE.
- cg_en  output  LENGTH  per-slot clock-gate/enable to the delay line (registered).
- reg_in  output  LENGTH*WIDTH  per-slot write data to the delay line (registered).
- rd_valid  output  1  tap index valid.
- rd_ready  input  1  consumer takes the tap index.
- rd_idx  output  PW  physical slot holding the current tap.
- rd_age  output  PW  tap age (0 = newest).
- rd_zero  output  1  tap not yet filled; consumer treats the value as 0.
- rd_last  output  1  final tap of the scan.
- fill  output  PW+1  number of valid samples stored, saturating at LENGTH.

Behaviour:
- Reset (synchronous, active-high; applies on any edge where reset=1, any state):
  - state <= IDLE; wr_ptr <= 0; fill <= 0.
  - cg_en <= 0; reg_in <= 0.
  - rd_valid, rd_zero, rd_last <= 0; rd_idx, rd_age <= 0.
  - in_ready = 0 while reset is high.
- in_ready = (state == IDLE) && !flush && !reset, combinational.
- States:
  - IDLE:
    - flush=1 -> FLUSH. Flush beats a simultaneous in_valid; no handshake completes that cycle.
    - else in_valid && in_ready -> WRITE. Register cg_en = onehot(wr_ptr) and every lane of reg_in = in_data.
  - WRITE (1 cycle):
    - cg_en is high for exactly this cycle; the slot captures at the closing edge.
    - At that edge: cg_en <= 0; wr_ptr <= (wr_ptr == LENGTH-1) ? 0 : wr_ptr+1; fill <= min(fill+1, LENGTH); age counter k <= 0; go to SCAN.
  - SCAN:
    - rd_valid = 1; rd_age = k.
    - rd_idx = (wr_ptr - 1 - k) mod LENGTH, where wr_ptr is the already-advanced pointer.
    - rd_zero = (k >= fill); rd_last = (k == LENGTH-1).
    - On rd_valid && rd_ready: k++. If rd_last, return to IDLE with rd_valid = 0.
    - With rd_ready low, all rd_* outputs hold stable.
  - FLUSH (1 cycle):
    - cg_en = all ones, reg_in = all zero.
    - At the closing edge: wr_ptr <= 0, fill <= 0, cg_en <= 0, return to IDLE.
- Only flip-flop outputs drive cg_en; it changes only on rising clk edges and never toggles mid-cycle.
- Zero cg_en activity outside WRITE and FLUSH.
- Per-sample throughput: 1 accept cycle + 1 WRITE cycle + LENGTH scan cycles (with rd_ready held high).
- in_valid is ignored outside IDLE; the sample is not consumed.
- flush outside IDLE is ignored; the requester holds flush until the controller returns to IDLE.
- Pointer wrap: slot LENGTH-1 is followed by slot 0. Index arithmetic is modulo LENGTH, including non-power-of-2 LENGTH.

Optional Feature:
- Macro CG_DELAY_CTRL_OLDEST_FIRST_EN.
- Defined:
  - Scan runs oldest to newest: rd_age = LENGTH-1-k.
  - rd_idx = (wr_ptr + k) mod LENGTH.
  - rd_zero = (LENGTH-1-k >= fill).
  - rd_last still marks the final scan beat (age 0).
- Undefined: newest-first order as specified above.

Test Plan (LENGTH=4, WIDTH=8, newest-first unless stated):
- Reset, then one sample 0x11 -> one WRITE cycle with cg_en=4'b0001 and reg_in lanes all 0x11. Then scan rd_idx 0,3,2,1 with rd_zero 0,1,1,1, rd_last on the 4th beat, fill=1.
- Samples 0x01..0x05 back-to-back -> 5th write uses cg_en=4'b0001 (wrap). Its scan gives rd_idx 0,3,2,1, all rd_zero=0, fill=4 (saturated).
- rd_ready held low 3 cycles on the 2nd scan beat -> rd_idx/rd_age stable, in_ready=0, a concurrent in_valid is not accepted, cg_en stays 0.
- 3 samples, then flush in IDLE -> one cycle cg_en=4'b1111 with reg_in=0. Next sample writes slot 0 and fill=1. flush && in_valid in the same IDLE cycle -> flush wins, in_ready=0.
- reset asserted during the 2nd SCAN beat -> next cycle rd_valid=0, cg_en=0, fill=0. The next sample writes slot 0.
- With CG_DELAY_CTRL_OLDEST_FIRST_EN and 2 samples written -> scan rd_idx 2,3,0,1 with rd_age 3,2,1,0 and rd_zero 1,1,0,0.
